// File: rtl/hamming_uart_pkg.sv
// Shared definitions for the Hamming(7,4) UART transmit path: state encoding,
// codeword position map and the reference encoder function.
package hamming_uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int FRAME_DATA_BITS = 7;

  // Codeword bit index for each Hamming position (position p lives at bit p-1)
  localparam int POS_P1 = 0;
  localparam int POS_P2 = 1;
  localparam int POS_D0 = 2;
  localparam int POS_P4 = 3;
  localparam int POS_D1 = 4;
  localparam int POS_D2 = 5;
  localparam int POS_D3 = 6;

  function automatic logic [FRAME_DATA_BITS-1:0] hamming74_encode(input logic [3:0] nibble);
    logic [FRAME_DATA_BITS-1:0] code;
    code         = '0;
    code[POS_D0] = nibble[0];
    code[POS_D1] = nibble[1];
    code[POS_D2] = nibble[2];
    code[POS_D3] = nibble[3];
    code[POS_P1] = nibble[0] ^ nibble[1] ^ nibble[3];
    code[POS_P2] = nibble[0] ^ nibble[2] ^ nibble[3];
    code[POS_P4] = nibble[1] ^ nibble[2] ^ nibble[3];
    return code;
  endfunction

endpackage

// File: rtl/hamming_uart_tx_encoder.sv
// Combinational Hamming(7,4) encoder; the receiver's syndrome equals the
// position of any single flipped bit in its output.
module hamming_encoder_74
  import hamming_uart_pkg::*;
(
  input  logic [3:0]                 data_i,
  output logic [FRAME_DATA_BITS-1:0] code_o
);

  assign code_o = hamming74_encode(data_i);

endmodule

// File: rtl/hamming_uart_tx.sv
// UART transmitter for Hamming(7,4) codewords: start bit, 7 code bits LSB
// first, stop bit, with optional single-bit error injection at accept time.
module hamming_uart_tx
  import hamming_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [3:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] err_inject,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic [1:0] state_out,
  output logic [6:0] code_out
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    IDX_LAST  = 3'(FRAME_DATA_BITS - 1);

  tx_state_e                  state_q, state_d;
  logic [CW-1:0]              baud_q, baud_d;
  logic [2:0]                 idx_q, idx_d;
  logic                       tx_q, tx_d;
  logic                       done_q, done_d;
  logic [FRAME_DATA_BITS-1:0] code_q, code_d;

  logic [FRAME_DATA_BITS-1:0] enc_code;
  logic [FRAME_DATA_BITS-1:0] err_mask;
  logic                       bit_end;

  hamming_encoder_74 u_enc (
    .data_i (in_data),
    .code_o (enc_code)
  );

  // One-hot flip mask: err_inject = N selects codeword bit N-1, zero selects none
  for (genvar gi = 0; gi < FRAME_DATA_BITS; gi++) begin : g_err_mask
    assign err_mask[gi] = (err_inject == 3'(gi + 1));
  end

  assign bit_end = (baud_q == BAUD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      code_q  <= '0;
    end else if (ena) begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    code_d  = code_q;

    if (state_q != ST_IDLE) begin
      baud_d = bit_end ? '0 : baud_q + CW'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_START;
          baud_d  = '0;
          idx_d   = '0;
          tx_d    = 1'b0;
          code_d  = enc_code ^ err_mask;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          idx_d   = '0;
          tx_d    = code_q[0];
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (idx_q == IDX_LAST) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = code_q[idx_q + 3'd1];
          end
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          state_d = ST_IDLE;
          tx_d    = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign busy      = (state_q != ST_IDLE);
  assign state_out = state_q;
  assign tx        = tx_q;
  assign done      = done_q;
  assign code_out  = code_q;

endmodule

// File: tb/tb_hamming_uart_tx.sv
// Directed bench for hamming_uart_tx: a line monitor decodes every frame and
// checks it against a scoreboard of codewords queued when stimulus is driven.
module tb_hamming_uart_tx;

  localparam int CPB = 4;

  logic       clk;
  logic       rst;
  logic       ena;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] err_inject;
  logic       tx;
  logic       busy;
  logic       done;
  logic [1:0] state_out;
  logic [6:0] code_out;

  typedef struct {
    logic [3:0] data;
    logic [2:0] err;
    logic [6:0] code;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  hamming_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .err_inject (err_inject),
    .tx         (tx),
    .busy       (busy),
    .done       (done),
    .state_out  (state_out),
    .code_out   (code_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Parity bits at positions 1,2,4 cover every data position whose index has that bit set
  function automatic logic [6:0] ref_encode(input logic [3:0] d, input logic [2:0] e);
    logic [7:1] c;
    int dpos[4] = '{3, 5, 6, 7};
    c = '0;
    for (int i = 0; i < 4; i++) c[dpos[i]] = d[i];
    for (int k = 0; k < 3; k++) begin
      logic p;
      p = 1'b0;
      for (int i = 0; i < 4; i++)
        if (((dpos[i] >> k) & 1) == 1) p = p ^ c[dpos[i]];
      c[1 << k] = p;
    end
    if (e != 3'd0) c[e] = ~c[e];
    return c;
  endfunction

  logic       ena_at_edge = 1'b0;
  logic       in_frame    = 1'b0;
  int         cnt         = 0;
  int         bit_pos;
  exp_t       cur;
  logic [7:1] rx_code;

  always @(posedge clk) ena_at_edge <= ena;

  // Line monitor: cnt advances only on enabled edges, so ena stalls stretch bits
  always @(negedge clk) begin
    if (rst) begin
      in_frame = 1'b0;
    end else begin
      if (!in_frame) begin
        if (tx === 1'b0) begin
          in_frame = 1'b1;
          cnt      = 0;
          rx_code  = '0;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL unexpected_frame observed=frame expected=none");
          end else begin
            cur = exp_q[0];
          end
        end else begin
          chk("idle_state", 32'(state_out), 32'd0);
          chk("idle_busy", 32'(busy), 32'd0);
          chk("idle_done", 32'(done), 32'd0);
          chk("idle_ready", 32'(in_ready), 32'd1);
        end
      end else if (ena_at_edge) begin
        cnt++;
      end

      if (in_frame) begin
        bit_pos = cnt / CPB;
        if (cnt == 9 * CPB) begin
          logic [2:0] syn;
          logic [7:1] fixed;
          chk("end_done", 32'(done), 32'd1);
          chk("end_state", 32'(state_out), 32'd0);
          chk("end_busy", 32'(busy), 32'd0);
          chk("end_ready", 32'(in_ready), 32'd1);
          chk("end_tx", 32'(tx), 32'd1);
          chk("frame_code_out", 32'(code_out), 32'(cur.code));
          chk("frame_rx_code", 32'(rx_code), 32'(cur.code));
          syn[0] = rx_code[1] ^ rx_code[3] ^ rx_code[5] ^ rx_code[7];
          syn[1] = rx_code[2] ^ rx_code[3] ^ rx_code[6] ^ rx_code[7];
          syn[2] = rx_code[4] ^ rx_code[5] ^ rx_code[6] ^ rx_code[7];
          fixed = rx_code;
          if (syn != 3'd0) fixed[syn] = ~fixed[syn];
          chk("rx_syndrome", 32'(syn), 32'(cur.err));
          chk("rx_data", 32'({fixed[7], fixed[6], fixed[5], fixed[3]}), 32'(cur.data));
          $display("frame data=%h err=%0d code=%h syndrome=%0d decoded=%h",
                   cur.data, cur.err, rx_code, syn, {fixed[7], fixed[6], fixed[5], fixed[3]});
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          in_frame = 1'b0;
        end else begin
          logic       exp_tx;
          logic [1:0] exp_st;
          if (bit_pos == 0) begin
            exp_tx = 1'b0; exp_st = 2'd1;
          end else if (bit_pos == 8) begin
            exp_tx = 1'b1; exp_st = 2'd3;
          end else begin
            exp_tx = cur.code[bit_pos - 1]; exp_st = 2'd2;
          end
          chk("bit_tx", 32'(tx), 32'(exp_tx));
          chk("bit_state", 32'(state_out), 32'(exp_st));
          chk("bit_busy", 32'(busy), 32'd1);
          chk("bit_ready", 32'(in_ready), 32'd0);
          chk("bit_done", 32'(done), 32'd0);
          if (bit_pos >= 1 && bit_pos <= 7 && (cnt % CPB) == CPB / 2)
            rx_code[bit_pos] = tx;
        end
      end
    end
  end

  task automatic send(input logic [3:0] d, input logic [2:0] e, input bit keep);
    int guard;
    exp_t item;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 500) begin
      checks++;
      failures++;
      $error("FAIL ready_timeout observed=0 expected=1");
    end
    in_data    = d;
    err_inject = e;
    in_valid   = 1'b1;
    item.data  = d;
    item.err   = e;
    item.code  = ref_encode(d, e);
    exp_q.push_back(item);
    @(negedge clk);
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 500);
    if (!done) begin
      checks++;
      failures++;
      $error("FAIL done_timeout observed=0 expected=1");
    end
  endtask

  initial begin
    int         n;
    logic       saved_tx;
    exp_t       item;

    rst        = 1'b1;
    ena        = 1'b1;
    in_data    = 4'h0;
    in_valid   = 1'b0;
    err_inject = 3'd0;
    repeat (2) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_state", 32'(state_out), 32'd0);
    chk("rst_code", 32'(code_out), 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 32'(in_ready), 32'd1);

    // Basic frame, nibble B, clean
    send(4'hB, 3'd0, 1'b0);
    chk("code_B", 32'(code_out), 32'h55);
    wait_done(n);
    chk("frame_len_B", 32'(n), 32'd36);

    // Back-to-back with in_valid held high
    send(4'h0, 3'd0, 1'b1);
    in_data    = 4'hF;
    item.data  = 4'hF;
    item.err   = 3'd0;
    item.code  = ref_encode(4'hF, 3'd0);
    exp_q.push_back(item);
    chk("code_0", 32'(code_out), 32'h00);
    wait_done(n);
    chk("frame_len_0", 32'(n), 32'd36);
    chk("gap_tx_idle", 32'(tx), 32'd1);
    chk("gap_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("gap_tx_start", 32'(tx), 32'd0);
    in_valid = 1'b0;
    chk("code_F", 32'(code_out), 32'h7F);
    wait_done(n);
    chk("frame_len_F", 32'(n), 32'd36);

    // Error injection at position 3
    send(4'hB, 3'd3, 1'b0);
    chk("code_B_err3", 32'(code_out), 32'h51);
    wait_done(n);

    // ena low for 10 cycles during data bit 3
    send(4'h6, 3'd0, 1'b0);
    repeat (4 * CPB + 1) @(negedge clk);
    ena      = 1'b0;
    saved_tx = tx;
    repeat (10) begin
      @(negedge clk);
      chk("stall_tx", 32'(tx), 32'(saved_tx));
      chk("stall_state", 32'(state_out), 32'd2);
    end
    ena = 1'b1;
    wait_done(n);
    chk("stall_frame_len", 32'(n + 4 * CPB + 1 + 10), 32'd46);

    // Reset during data bit 5
    send(4'h9, 3'd5, 1'b0);
    repeat (6 * CPB + 1) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_tx", 32'(tx), 32'd1);
    chk("abort_state", 32'(state_out), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_code", 32'(code_out), 32'd0);
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'd0);
    end
    rst = 1'b0;
    send(4'h9, 3'd5, 1'b0);
    wait_done(n);
    chk("after_abort_len", 32'(n), 32'd36);

    // Full sweep of nibbles and injection positions
    for (int d = 0; d < 16; d++) begin
      for (int e = 0; e < 8; e++) begin
        send(4'(d), 3'(e), 1'b0);
        wait_done(n);
      end
    end

    @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
